// File: rtl/result_printer_pkg.sv
// Shared definitions for the RPN calculator result printer: ASCII codes,
// decimal place table and the state encodings of both FSMs.
package result_printer_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int REM_W   = 17;
    localparam int LAST_P  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIGN,
        ST_CONV,
        ST_SEND,
        ST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Powers of ten, most significant place first.
    function automatic logic [REM_W-1:0] pow10(input logic [2:0] p);
        logic [REM_W-1:0] v;
        case (p)
            3'd0:    v = 17'd10000;
            3'd1:    v = 17'd1000;
            3'd2:    v = 17'd100;
            3'd3:    v = 17'd10;
            default: v = 17'd1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/result_printer_uart_tx.sv
// Generic 8N1 UART transmitter (the uart_tx block), LSB first.
// Accepts a byte on tx_start while idle and pulses tx_done on the last
// cycle of the stop bit so a sender can chain the next byte without a gap.
module result_printer_uart_tx
    import result_printer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [CNT_W-1:0] w_clk_cnt_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_tx_out;
    logic             w_tx_out_nxt;
    logic             w_last_clk;

    assign w_last_clk = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign tx_out     = r_tx_out;
    assign tx_busy    = (r_state != TX_IDLE);
    assign tx_done    = (r_state == TX_STOP) && w_last_clk;

    // Control state; reset drives the line high at once, mid-frame or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= TX_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_tx_out  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_tx_out  <= w_tx_out_nxt;
        end
    end

    // Data shift register needs no reset; it is loaded before every frame.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    // Bit sequencing: start, eight data bits, stop, each CLKS_PER_BIT long.
    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_out_nxt  = r_tx_out;
        case (r_state)
            TX_IDLE: begin
                w_tx_out_nxt  = 1'b1;
                w_clk_cnt_nxt = '0;
                if (tx_start) begin
                    w_state_nxt   = TX_START;
                    w_tx_out_nxt  = 1'b0;
                    w_shift_nxt   = tx_data;
                    w_bit_idx_nxt = '0;
                end
            end
            TX_START: begin
                if (w_last_clk) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = TX_DATA;
                    w_tx_out_nxt  = r_shift[0];
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (w_last_clk) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt  = TX_STOP;
                        w_tx_out_nxt = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_tx_out_nxt  = r_shift[1];
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (w_last_clk) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = TX_IDLE;
                    w_tx_out_nxt  = 1'b1;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = TX_IDLE;
                w_clk_cnt_nxt = '0;
                w_tx_out_nxt  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/result_printer.sv
// RPN calculator result printer: converts a 16-bit result to decimal ASCII
// by repeated subtraction of powers of ten and sends it, followed by CR LF,
// through the UART transmitter. One result is printed per line.
module result_printer
    import result_printer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter bit SIGNED       = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        num_valid,
    input  logic [15:0] num,
    output logic        ready,
    output logic        tx_out
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [REM_W-1:0] r_rem;
    logic [REM_W-1:0] w_rem_nxt;
    logic [2:0]       r_p;
    logic [2:0]       w_p_nxt;
    logic [3:0]       r_d;
    logic [3:0]       w_d_nxt;
    logic             r_started;
    logic             w_started_nxt;
    logic [1:0]       r_sfx;
    logic [1:0]       w_sfx_nxt;
    logic             r_sign_sent;
    logic             w_sign_sent_nxt;
    logic [7:0]       r_byte;
    logic [7:0]       w_byte_nxt;

    logic             w_neg;
    logic [REM_W-1:0] w_mag;
    logic [REM_W-1:0] w_pow;
    logic             w_tx_start;
    logic             w_tx_busy;
    logic             w_tx_done;

    // Magnitude in 17 bits so that 0x8000 negates to 32768 without overflow.
    assign w_neg = SIGNED && num[15];
    assign w_mag = w_neg ? ({1'b0, ~num} + 17'd1) : {1'b0, num};
    assign w_pow = pow10(r_p);

    assign ready      = (r_state == ST_IDLE);
    assign w_tx_start = (r_state == ST_SEND) && !w_tx_busy;

    result_printer_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk      (clk),
        .rst      (rst),
        .tx_start (w_tx_start),
        .tx_data  (r_byte),
        .tx_out   (tx_out),
        .tx_busy  (w_tx_busy),
        .tx_done  (w_tx_done)
    );

    // State and conversion counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_p         <= '0;
            r_d         <= '0;
            r_started   <= 1'b0;
            r_sfx       <= '0;
            r_sign_sent <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_p         <= w_p_nxt;
            r_d         <= w_d_nxt;
            r_started   <= w_started_nxt;
            r_sfx       <= w_sfx_nxt;
            r_sign_sent <= w_sign_sent_nxt;
        end
    end

    // Outgoing byte; always written before SEND so it carries no reset.
    always_ff @(posedge clk) begin
        r_byte <= w_byte_nxt;
    end

    // Conversion and byte sequencing: sign, digits, CR, LF.
    always_comb begin
        w_state_nxt     = r_state;
        w_rem_nxt       = r_rem;
        w_p_nxt         = r_p;
        w_d_nxt         = r_d;
        w_started_nxt   = r_started;
        w_sfx_nxt       = r_sfx;
        w_sign_sent_nxt = r_sign_sent;
        w_byte_nxt      = r_byte;
        case (r_state)
            ST_IDLE: begin
                if (num_valid) begin
                    w_rem_nxt       = w_mag;
                    w_p_nxt         = '0;
                    w_d_nxt         = '0;
                    w_started_nxt   = 1'b0;
                    w_sfx_nxt       = '0;
                    w_sign_sent_nxt = 1'b0;
                    w_state_nxt     = w_neg ? ST_SIGN : ST_CONV;
                end
            end
            ST_SIGN: begin
                w_byte_nxt      = ASCII_MINUS;
                w_sign_sent_nxt = 1'b1;
                w_state_nxt     = ST_SEND;
            end
            ST_CONV: begin
                if (r_rem >= w_pow) begin
                    w_rem_nxt = r_rem - w_pow;
                    w_d_nxt   = r_d + 4'd1;
                end else if ((r_d != 4'd0) || r_started || (r_p == 3'(LAST_P))) begin
                    // Units place is always printed so zero shows as "0".
                    w_byte_nxt    = ASCII_ZERO + {4'b0000, r_d};
                    w_started_nxt = 1'b1;
                    w_state_nxt   = ST_SEND;
                end else begin
                    w_p_nxt = r_p + 3'd1;
                    w_d_nxt = '0;
                end
            end
            ST_SEND: begin
                if (!w_tx_busy) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_tx_done) begin
                    if (r_sign_sent) begin
                        w_sign_sent_nxt = 1'b0;
                        w_state_nxt     = ST_CONV;
                    end else if ((r_sfx == 2'd0) && (r_p < 3'(LAST_P))) begin
                        w_p_nxt     = r_p + 3'd1;
                        w_d_nxt     = '0;
                        w_state_nxt = ST_CONV;
                    end else if (r_sfx == 2'd0) begin
                        w_byte_nxt  = ASCII_CR;
                        w_sfx_nxt   = 2'd1;
                        w_state_nxt = ST_SEND;
                    end else if (r_sfx == 2'd1) begin
                        w_byte_nxt  = ASCII_LF;
                        w_sfx_nxt   = 2'd2;
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_result_printer.sv
// Bench for result_printer: two instances (unsigned and signed) with a
// UART decoder per line feeding a byte scoreboard.
module tb_result_printer;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        nv_u, nv_s;
    logic [15:0] num_u, num_s;
    logic        ready_u, ready_s;
    logic        tx_u, tx_s;

    int checks   = 0;
    int failures = 0;
    int rx_cnt_u = 0;
    int rx_cnt_s = 0;

    logic [7:0] q_u[$];
    logic [7:0] q_s[$];

    always #5 clk = ~clk;

    result_printer #(.CLKS_PER_BIT(CPB), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .num_valid(nv_u), .num(num_u),
        .ready(ready_u), .tx_out(tx_u)
    );

    result_printer #(.CLKS_PER_BIT(CPB), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .num_valid(nv_s), .num(num_s),
        .ready(ready_s), .tx_out(tx_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decoder: detect start at a negedge, sample each bit mid-period.
    task automatic rx_loop(input int which);
        bit         busy = 1'b0;
        int         cnt  = 0;
        logic [7:0] sh   = 8'h00;
        logic [7:0] exp;
        logic       line;
        forever begin
            @(negedge clk);
            line = (which != 0) ? tx_s : tx_u;
            if (rst) begin
                busy = 1'b0;
            end else if (!busy) begin
                if (line === 1'b0) begin
                    busy = 1'b1;
                    cnt  = 0;
                end
            end else begin
                cnt++;
                if (cnt >= 5 && cnt <= 33 && ((cnt - 5) % 4) == 0)
                    sh[3'((cnt - 5) / 4)] = line;
                if (cnt == 37) begin
                    busy = 1'b0;
                    if (which != 0) begin
                        chk("stop_bit_s", {31'd0, line}, 32'd1);
                        chk("byte_expected_s", {31'd0, q_s.size() > 0}, 32'd1);
                        if (q_s.size() > 0) begin
                            exp = q_s.pop_front();
                            chk("rx_byte_s", {24'd0, sh}, {24'd0, exp});
                        end
                        rx_cnt_s++;
                    end else begin
                        chk("stop_bit_u", {31'd0, line}, 32'd1);
                        chk("byte_expected_u", {31'd0, q_u.size() > 0}, 32'd1);
                        if (q_u.size() > 0) begin
                            exp = q_u.pop_front();
                            chk("rx_byte_u", {24'd0, sh}, {24'd0, exp});
                        end
                        rx_cnt_u++;
                    end
                end
            end
        end
    endtask

    initial rx_loop(0);
    initial rx_loop(1);

    task automatic push_str(input int which, input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (which != 0) q_s.push_back(8'(s[i]));
            else            q_u.push_back(8'(s[i]));
        end
        if (which != 0) begin q_s.push_back(8'h0D); q_s.push_back(8'h0A); end
        else            begin q_u.push_back(8'h0D); q_u.push_back(8'h0A); end
    endtask

    task automatic issue(input int which, input logic [15:0] v);
        @(negedge clk);
        chk("ready_before", {31'd0, (which != 0) ? ready_s : ready_u}, 32'd1);
        if (which != 0) begin num_s = v; nv_s = 1'b1; end
        else            begin num_u = v; nv_u = 1'b1; end
        @(negedge clk);
        nv_u = 1'b0;
        nv_s = 1'b0;
        chk("ready_fall", {31'd0, (which != 0) ? ready_s : ready_u}, 32'd0);
    endtask

    task automatic wait_done(input int which, input string tag);
        int n = 0;
        while ((((which != 0) ? ready_s : ready_u) !== 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, {31'd0, n < 3000}, 32'd1);
        chk({tag, "_all_bytes"}, (which != 0) ? q_s.size() : q_u.size(), 32'd0);
    endtask

    task automatic print(input int which, input logic [15:0] v, input string s, input string tag);
        push_str(which, s);
        issue(which, v);
        wait_done(which, tag);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int n;
        rst   = 1'b1;
        nv_u  = 1'b0;
        nv_s  = 1'b0;
        num_u = 16'h0;
        num_s = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready_u", {31'd0, ready_u}, 32'd1);
        chk("rst_tx_u", {31'd0, tx_u}, 32'd1);
        chk("rst_ready_s", {31'd0, ready_s}, 32'd1);
        chk("rst_tx_s", {31'd0, tx_s}, 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_tx_u", {31'd0, tx_u}, 32'd1);
        chk("idle_ready_u", {31'd0, ready_u}, 32'd1);

        print(0, 16'd0, "0", "zero");
        print(0, 16'd12345, "12345", "n12345");
        print(0, 16'd100, "100", "n100");
        print(0, 16'hFFFF, "65535", "u_ffff");
        print(1, 16'hFFFF, "-1", "s_ffff");
        print(1, 16'h8000, "-32768", "s_8000");
        print(1, 16'h7FFF, "32767", "s_7fff");
        print(1, 16'd0, "0", "s_zero");

        // Value offered while busy must be dropped.
        base = rx_cnt_u;
        push_str(0, "7");
        issue(0, 16'd7);
        repeat (20) @(negedge clk);
        num_u = 16'd999;
        nv_u  = 1'b1;
        @(negedge clk);
        nv_u  = 1'b0;
        wait_done(0, "drop");
        repeat (200) @(negedge clk);
        chk("drop_frames", rx_cnt_u - base, 32'd3);
        chk("drop_line_idle", {31'd0, tx_u}, 32'd1);
        chk("drop_ready", {31'd0, ready_u}, 32'd1);

        // Reset during data bit 1 of the second digit frame.
        base = rx_cnt_u;
        push_str(0, "58");
        issue(0, 16'd58);
        n = 0;
        while (rx_cnt_u != base + 1 && n < 3000) begin @(negedge clk); n++; end
        chk("rst_first_digit", {31'd0, n < 3000}, 32'd1);
        n = 0;
        while (tx_u !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        chk("rst_second_start", {31'd0, n < 100}, 32'd1);
        repeat (10) @(negedge clk);
        chk("rst_mid_bit_busy", {31'd0, ready_u}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_async_tx", {31'd0, tx_u}, 32'd1);
        chk("rst_async_ready", {31'd0, ready_u}, 32'd1);
        chk("rst_pending_bytes", q_u.size(), 32'd3);
        q_u.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("rst_no_tail", rx_cnt_u - base, 32'd1);
        print(0, 16'd42, "42", "after_rst");

        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_printer.md
# result_printer

Transmit side of the RPN calculator's serial link. Accepts a 16-bit result word from the evaluation stack, converts it to decimal ASCII, and sends the characters followed by CR LF over a UART line (8N1, LSB first). A terminal connected to the RX pin therefore sees one result per line.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200).
- `SIGNED`, default 0: when 1, `num` is two's complement and negative values are printed with a leading '-'.

Ports:
- `clk`  in  1  system clock. This is the only clock in the block.
- `rst`  in  1  reset, asynchronous and active-high.
- `num_valid`  in  1  one-cycle strobe: `num` is valid. It is sampled only while `ready`=1.
- `num`  in  16  result word.
- `ready`  out  1  high when the block is idle and can accept `num_valid`.
- `tx_out`  out  1  UART serial line. It idles high.

## Operation
- States: IDLE, SIGN, CONV, SEND, WAIT.
- IDLE:
  - `ready`=1.
  - On `num_valid`, latch the magnitude into `rem`.
  - Set place index `p`=0, digit count `d`=0, `started`=0, and suffix counter `sfx`=0.
  - If `SIGNED` and `num[15]`, go to SIGN. Otherwise go to CONV.
- Magnitude when `SIGNED`=1 and `num[15]`=1: `rem` = (~num)+1, computed in 17 bits. 0x8000 yields 32768.
- SIGN: load byte 0x2D ('-'), go to SEND, and return to CONV after the byte is sent.
- CONV uses the powers-of-ten table POW[0..4] = 10000, 1000, 100, 10, 1. Each cycle:
  - If `rem` >= POW[p]: `rem` -= POW[p], `d`++.
  - Else, if `d`≠0, or `started`, or `p`=4: load byte 0x30+`d`, set `started`=1, go to SEND.
  - Else (leading zero): `p`++, `d`=0, stay in CONV.
- SEND: assert `tx_start` to the `uart_tx` sub-module for exactly one cycle, then go to WAIT.
- WAIT: on `tx_done` from `uart_tx`, choose the next step in this order:
  - sign just sent → CONV.
  - digit sent with `p`<4 → `p`++, `d`=0, CONV.
  - last digit sent → load 0x0D, `sfx`=1, SEND.
  - `sfx`=1 → load 0x0A, `sfx`=2, SEND.
  - `sfx`=2 → IDLE.
- `num_valid` while `ready`=0 is ignored. The value is dropped, there is no queue, and the upstream block must honour `ready`.
- `uart_tx` behaviour:
  - Accepts `tx_start` only when idle.
  - Sends start bit (0), data bits 0..7, then stop bit (1). Each bit lasts `CLKS_PER_BIT` cycles.
  - Pulses `tx_done` for one cycle on the last cycle of the stop bit.
- Arithmetic: `rem` is 17 bits and `d` is 4 bits. `d` never exceeds 9 because `rem` < 10·POW[p] whenever place `p` is processed.

## Timing
- Reset values: state=IDLE, `ready`=1, `tx_out`=1, and all counters 0.
- Reset asserted mid-frame forces `tx_out`=1 immediately. No partial stop bit is emitted.
- `ready` falls on the clock edge that samples `num_valid`. It rises on the edge after `tx_done` for LF.
- CONV spends at most 10 cycles per printed place and 1 cycle per suppressed leading zero.
- `tx_out` goes low (start bit) on the edge after `tx_start` is sampled.
- One frame is exactly 10·`CLKS_PER_BIT` cycles.
- Inter-character gap is at most 12 cycles: WAIT → CONV (≤10) → SEND → start.
- Zero prints as a single "0" (forced at `p`=4). Negative zero cannot occur.
- 0xFFFF prints "65535" when `SIGNED`=0 and "-1" when `SIGNED`=1.

## Structure
- Shared include `rpn_defs.vh` holds:
  - ASCII constants: `ASCII_ZERO`=0x30, `ASCII_MINUS`=0x2D, `ASCII_CR`=0x0D, `ASCII_LF`=0x0A.
  - The POW table.
  - State encodings.
- `uart_tx` is a separate sub-module, reusable by other senders.
  - Ports: `clk`, `rst`, `tx_start`, `tx_data[7:0]`, `tx_out`, `tx_busy`, `tx_done`.
- `result_printer` contains only the conversion FSM and the byte sequencing.

## Test plan
- Run with `CLKS_PER_BIT`=4 and a bench UART decoder on `tx_out`.
- `num`=0 → bytes 0x30 0x0D 0x0A. `ready` stays low for the whole transfer, then returns to 1.
- `num`=12345, then `num`=100 after `ready` rises → "12345\r\n" then "100\r\n". No leading zeros, and interior zeros are kept.
- `SIGNED`=0, `num`=0xFFFF → "65535\r\n".
- `SIGNED`=1:
  - 0xFFFF → "-1\r\n".
  - 0x8000 → "-32768\r\n".
  - 0x7FFF → "32767\r\n".
- `num_valid` pulsed with 999 while busy printing 7 → only "7\r\n" is emitted, and 999 is dropped.
- `rst` asserted during the third bit of the second digit → `tx_out`=1 and `ready`=1 the same cycle. A subsequent `num`=42 prints "42\r\n" cleanly.
